// File: rtl/i2c_pkg.sv
// Shared I2C types: FSM state encoding, the STOP generator register struct and
// the quarter-bit count helper. I2C_STOP_STRETCH_TIMEOUT_EN adds the timeout status bit.
package i2c_pkg;

    localparam int unsigned CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PULL    = 3'd1,
        SCL_REL = 3'd2,
        SDA_REL = 3'd3,
        DONE    = 3'd4
    } state_t;

    typedef struct packed {
        state_t           state;
        logic [CNT_W-1:0] cnt;
        logic             scl_hi;
        logic             sda_drive;
        logic             scl_drive;
        logic             done;
`ifdef I2C_STOP_STRETCH_TIMEOUT_EN
        logic             timeout;
`endif
    } stop_reg_t;

    function automatic int unsigned quarter_cnt(input int unsigned clk_freq,
                                                input int unsigned i2c_freq);
        int unsigned q;
        q = clk_freq / (4 * i2c_freq);
        return (q == 0) ? 1 : q;
    endfunction

endpackage

// File: rtl/i2c_sync2.sv
// Two-flop synchroniser for an asynchronous bus line; shared by the START and STOP generators.
module i2c_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/i2c_stop_generator.sv
// I2C STOP condition generator (SDA rises while SCL is high), honouring clock stretching.
// Define I2C_STOP_STRETCH_TIMEOUT_EN to abort a stretch that exceeds 64 quarter-bits.
module i2c_stop_generator
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 25_000_000,
    parameter int unsigned I2C_FREQ = 1_000_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_req,
    output logic o_ready,
    output logic o_done,
    input  logic i_sda,
    input  logic i_scl,
    output logic o_sda_drive,
    output logic o_scl_drive
);

    localparam int unsigned      Q         = quarter_cnt(CLK_FREQ, I2C_FREQ);
    localparam logic [CNT_W-1:0] PULL_LAST = CNT_W'(Q - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(2 * Q - 1);
`ifdef I2C_STOP_STRETCH_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TOUT_LAST = CNT_W'(64 * Q - 1);
`endif

    logic      w_scl_sync;
    logic      w_sda_sync;
    logic      w_sda_sync_unused;
    logic      w_accept;
    stop_reg_t s_r;
    stop_reg_t s_n;

    // Both lines idle high, so the synchronisers reset to 1.
    i2c_sync2 #(.RST_VAL(1'b1)) u_sync_scl (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_scl),
        .o_q   (w_scl_sync)
    );

    i2c_sync2 #(.RST_VAL(1'b1)) u_sync_sda (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_sda),
        .o_q   (w_sda_sync)
    );

    // The SDA level is kept synchronised for bus monitoring; no STOP decision depends on it.
    assign w_sda_sync_unused = w_sda_sync;

    assign o_ready  = (s_r.state == IDLE) && !w_scl_sync;
    assign w_accept = i_req && o_ready;

    always_comb begin
        s_n     = s_r;
        s_n.cnt = s_r.cnt + CNT_W'(1);
        case (s_r.state)
            IDLE: begin
                s_n.cnt    = '0;
                s_n.scl_hi = 1'b0;
                if (w_accept) begin
                    s_n.state   = PULL;
`ifdef I2C_STOP_STRETCH_TIMEOUT_EN
                    s_n.timeout = 1'b0;
`endif
                end
            end
            PULL: begin
                if (s_r.cnt == PULL_LAST) begin
                    s_n.state = SCL_REL;
                    s_n.cnt   = '0;
                end
            end
            SCL_REL: begin
                if (!s_r.scl_hi) begin
                    // The cycle SCL is first seen high counts as the first setup cycle.
                    if (w_scl_sync) begin
                        s_n.scl_hi = 1'b1;
                        s_n.cnt    = CNT_W'(1);
`ifdef I2C_STOP_STRETCH_TIMEOUT_EN
                    end else if (s_r.cnt == TOUT_LAST) begin
                        s_n.state   = DONE;
                        s_n.cnt     = '0;
                        s_n.timeout = 1'b1;
                    end
`else
                    end else begin
                        s_n.cnt = '0;
                    end
`endif
                end else if (s_r.cnt == HOLD_LAST) begin
                    s_n.state = SDA_REL;
                    s_n.cnt   = '0;
                end
            end
            SDA_REL: begin
                if (s_r.cnt == HOLD_LAST) begin
                    s_n.state = DONE;
                    s_n.cnt   = '0;
                end
            end
            DONE: begin
                s_n.state = IDLE;
                s_n.cnt   = '0;
            end
            default: begin
                s_n.state = IDLE;
                s_n.cnt   = '0;
            end
        endcase

        // Drives and done are decoded from the next state so they leave the flops glitch-free.
        s_n.scl_drive = (s_n.state != PULL);
        s_n.sda_drive = (s_n.state != PULL) && (s_n.state != SCL_REL);
        s_n.done      = (s_n.state == DONE);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            s_r.state     <= IDLE;
            s_r.cnt       <= '0;
            s_r.scl_hi    <= 1'b0;
            s_r.sda_drive <= 1'b1;
            s_r.scl_drive <= 1'b1;
            s_r.done      <= 1'b0;
`ifdef I2C_STOP_STRETCH_TIMEOUT_EN
            s_r.timeout   <= 1'b0;
`endif
        end else begin
            s_r <= s_n;
        end
    end

    assign o_sda_drive = s_r.sda_drive;
    assign o_scl_drive = s_r.scl_drive;
    assign o_done      = s_r.done;

endmodule

// File: tb/tb_i2c_stop_generator.sv
// Self-checking bench for i2c_stop_generator with an open-drain bus model.
`timescale 1ns/1ps
module tb_i2c_stop_generator;

    localparam int unsigned CLK_FREQ = 25_000_000;
    localparam int unsigned I2C_FREQ = 1_000_000;
    localparam int          Q_RAW    = CLK_FREQ / (4 * I2C_FREQ);
    localparam int          Q        = (Q_RAW < 1) ? 1 : Q_RAW;
    localparam int          SYNC_LAT = 2;

    logic i_clk = 1'b0;
    logic i_rst = 1'b0;
    logic i_req = 1'b0;
    logic o_ready, o_done, o_sda_drive, o_scl_drive;
    logic tb_sda_rel = 1'b1;
    logic tb_scl_rel = 1'b1;
    logic sda_bus, scl_bus;

    int checks   = 0;
    int failures = 0;

    // Wired-AND bus: either side pulling low wins.
    assign sda_bus = o_sda_drive & tb_sda_rel;
    assign scl_bus = o_scl_drive & tb_scl_rel;

    i2c_stop_generator #(
        .CLK_FREQ (CLK_FREQ),
        .I2C_FREQ (I2C_FREQ)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req       (i_req),
        .o_ready     (o_ready),
        .o_done      (o_done),
        .i_sda       (sda_bus),
        .i_scl       (scl_bus),
        .o_sda_drive (o_sda_drive),
        .o_scl_drive (o_scl_drive)
    );

    always #20 i_clk = ~i_clk;

    task automatic test_reset();
        i_rst = 1'b0; i_req = 1'b0; tb_sda_rel = 1'b1; tb_scl_rel = 1'b1;
        repeat (2) @(negedge i_clk);
        checks++;
        if (o_sda_drive !== 1'b1 || o_scl_drive !== 1'b1) begin
            failures++;
            $display("FAIL reset_drives: sda_drive=%b scl_drive=%b, required 1/1", o_sda_drive, o_scl_drive);
        end
        checks++;
        if (o_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_done: o_done=%b, required 0", o_done);
        end
        checks++;
        if (dut.s_r.state !== 0) begin
            failures++;
            $display("FAIL reset_state: state=%0d, required 0", dut.s_r.state);
        end
        i_rst = 1'b1;
        @(negedge i_clk);
    endtask

    task automatic test_idle_bus();
        tb_sda_rel = 1'b1; tb_scl_rel = 1'b1;
        repeat (4) @(negedge i_clk);
        i_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            checks++;
            if (dut.s_r.state !== 0 || o_ready !== 1'b0 || o_done !== 1'b0) begin
                failures++;
                $display("FAIL idle_bus_cycle%0d: state=%0d ready=%b done=%b, required 0/0/0",
                         i, dut.s_r.state, o_ready, o_done);
            end
        end
        i_req = 1'b0;
        @(negedge i_clk);
    endtask

    // Full STOP with the bench stretching SCL for 'stretch' cycles after the DUT releases it.
    task automatic test_stop_sequence(input string tag, input int stretch, input bit sda_low);
        int c, c_scl_up, c_brel, c_sda_up, c_done;
        bit sda_dipped, scl_stay, post_ok;
        tb_scl_rel = 1'b0;
        tb_sda_rel = !sda_low;
        c = 0;
        @(negedge i_clk);
        while (o_ready !== 1'b1 && c < 8) begin
            @(negedge i_clk);
            c++;
        end
        checks++;
        if (o_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_ready_rise: o_ready=%b, required 1 within 8 cycles", tag, o_ready);
            tb_scl_rel = 1'b1; tb_sda_rel = 1'b1;
            return;
        end
        i_req = 1'b1;
        @(negedge i_clk);
        i_req = 1'b0;
        tb_sda_rel = 1'b1;
        checks++;
        if (o_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s_ready_fall: o_ready=%b, required 0", tag, o_ready);
        end
        c_scl_up = -1; c_brel = -1; c_sda_up = -1; c_done = -1;
        sda_dipped = 1'b0; scl_stay = 1'b1;
        for (c = 0; c < 400 && c_done < 0; c++) begin
            if (c > 0) @(negedge i_clk);
            if (sda_bus === 1'b0) sda_dipped = 1'b1;
            if (c_scl_up < 0 && o_scl_drive === 1'b1) c_scl_up = c;
            if (c_scl_up >= 0 && o_scl_drive !== 1'b1) scl_stay = 1'b0;
            if (c_scl_up >= 0 && c_sda_up < 0 && o_sda_drive === 1'b1) c_sda_up = c;
            if (o_done === 1'b1) c_done = c;
            if (c_scl_up >= 0 && c_brel < 0 && c == c_scl_up + stretch) begin
                tb_scl_rel = 1'b1;
                c_brel = c;
            end
        end
        tb_scl_rel = 1'b1;
        checks++;
        if (c_scl_up != Q) begin
            failures++;
            $display("FAIL %s_pull_len: SCL released after %0d cycles, required %0d", tag, c_scl_up, Q);
        end
        checks++;
        if (!sda_dipped) begin
            failures++;
            $display("FAIL %s_sda_dip: SDA never seen low, required a low phase", tag);
        end
        checks++;
        if (c_brel < 0 || c_sda_up < 0 || (c_sda_up - c_brel) != 2 * Q + SYNC_LAT) begin
            failures++;
            $display("FAIL %s_setup_len: SDA rose %0d cycles after bus SCL rose, required %0d",
                     tag, c_sda_up - c_brel, 2 * Q + SYNC_LAT);
        end
        checks++;
        if (c_done < 0 || c_sda_up < 0 || (c_done - c_sda_up) != 2 * Q) begin
            failures++;
            $display("FAIL %s_free_len: done %0d cycles after SDA rose, required %0d",
                     tag, c_done - c_sda_up, 2 * Q);
        end
        checks++;
        if (!scl_stay) begin
            failures++;
            $display("FAIL %s_scl_stay: scl_drive fell after release, required held at 1", tag);
        end
        checks++;
        if (c_done < 0 || sda_bus !== 1'b1 || scl_bus !== 1'b1) begin
            failures++;
            $display("FAIL %s_bus_at_done: done_seen=%0d sda=%b scl=%b, required done with 1/1",
                     tag, c_done >= 0, sda_bus, scl_bus);
        end
        post_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            if (o_done !== 1'b0 || sda_bus !== 1'b1 || scl_bus !== 1'b1) post_ok = 1'b0;
        end
        checks++;
        if (!post_ok || dut.s_r.state !== 0) begin
            failures++;
            $display("FAIL %s_after_done: lines/done not stable or state=%0d, required 1/1, done 0, state 0",
                     tag, dut.s_r.state);
        end
    endtask

    task automatic test_reset_mid();
        int c;
        bit no_done;
        tb_scl_rel = 1'b0; tb_sda_rel = 1'b1;
        c = 0;
        @(negedge i_clk);
        while (o_ready !== 1'b1 && c < 8) begin
            @(negedge i_clk);
            c++;
        end
        i_req = 1'b1;
        @(negedge i_clk);
        i_req = 1'b0;
        c = 0;
        while (o_scl_drive !== 1'b1 && c < 20) begin
            @(negedge i_clk);
            c++;
        end
        repeat (3) @(negedge i_clk);
        checks++;
        if (o_scl_drive !== 1'b1 || o_sda_drive !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_in_sclrel: scl_drive=%b sda_drive=%b, required 1/0", o_scl_drive, o_sda_drive);
        end
        #5 i_rst = 1'b0;
        #1;
        checks++;
        if (o_scl_drive !== 1'b1 || o_sda_drive !== 1'b1 || dut.s_r.state !== 0) begin
            failures++;
            $display("FAIL rstmid_async: scl_drive=%b sda_drive=%b state=%0d, required 1/1/0",
                     o_scl_drive, o_sda_drive, dut.s_r.state);
        end
        @(negedge i_clk);
        i_rst = 1'b1;
        no_done = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge i_clk);
            if (o_done !== 1'b0 || dut.s_r.state !== 0) no_done = 1'b0;
        end
        checks++;
        if (!no_done) begin
            failures++;
            $display("FAIL rstmid_no_done: done pulsed or STOP resumed after reset, required idle");
        end
        tb_scl_rel = 1'b1;
        repeat (4) @(negedge i_clk);
    endtask

    task automatic test_req_held();
        int c;
        bit stayed;
        tb_scl_rel = 1'b0; tb_sda_rel = 1'b1;
        i_req = 1'b1;
        c = 0;
        while (o_scl_drive !== 1'b0 && c < 10) begin
            @(negedge i_clk);
            c++;
        end
        c = 0;
        while (o_scl_drive !== 1'b1 && c < 20) begin
            @(negedge i_clk);
            c++;
        end
        tb_scl_rel = 1'b1;
        c = 0;
        while (o_done !== 1'b1 && c < 100) begin
            @(negedge i_clk);
            c++;
        end
        checks++;
        if (o_done !== 1'b1) begin
            failures++;
            $display("FAIL held_first_done: o_done=%b, required 1 within 100 cycles", o_done);
        end
        stayed = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge i_clk);
            if (dut.s_r.state !== 0 || o_scl_drive !== 1'b1 || o_sda_drive !== 1'b1) stayed = 1'b0;
        end
        checks++;
        if (!stayed) begin
            failures++;
            $display("FAIL held_no_restart: STOP restarted with SCL high, required idle");
        end
        tb_scl_rel = 1'b0;
        c = 0;
        while (dut.s_r.state === 0 && c < 6) begin
            @(negedge i_clk);
            c++;
        end
        checks++;
        if (dut.s_r.state === 0) begin
            failures++;
            $display("FAIL held_restart: state=%0d, required a new STOP once SCL low", dut.s_r.state);
        end
        i_req = 1'b0;
        c = 0;
        while (o_scl_drive !== 1'b1 && c < 20) begin
            @(negedge i_clk);
            c++;
        end
        tb_scl_rel = 1'b1;
        c = 0;
        while (o_done !== 1'b1 && c < 100) begin
            @(negedge i_clk);
            c++;
        end
        checks++;
        if (o_done !== 1'b1) begin
            failures++;
            $display("FAIL held_second_done: o_done=%b, required 1 within 100 cycles", o_done);
        end
        repeat (4) @(negedge i_clk);
    endtask

    task automatic test_random();
        int st;
        bit sl;
        for (int i = 0; i < 6; i++) begin
            st = int'($urandom_range(0, 60));
            sl = 1'($urandom_range(0, 1));
            repeat (int'($urandom_range(0, 5))) @(negedge i_clk);
            test_stop_sequence($sformatf("rand%0d_st%0d", i, st), st, sl);
        end
    endtask

    initial begin
        test_reset();
        test_idle_bus();
        test_stop_sequence("pull_both", 0, 1'b1);
        test_stop_sequence("sda_high", 0, 1'b0);
        test_stop_sequence("stretch50", 50, 1'b0);
        test_reset_mid();
        test_req_held();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
